mem_access_unit: RTL and testbench

Memory-stage access controller between the EX/MEM pipeline register and the data-memory bus. It turns the registered load/store controls (`MemR_m`, `MemW_m`, address, store data, access size) into a single-outstanding request/grant/response transaction. It produces the aligned, extended load result for the MEM/WB register, and holds `stall_m` high until the access completes so the hazard unit can freeze the upstream stages.

---
 rtl/mem_access_unit_pkg.sv | 50 +++++
 rtl/mem_access_unit_load_align.sv | 35 +++
 rtl/mem_access_unit.sv | 122 ++++++++++++
 tb/tb_mem_access_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared types, strobe constants and lane helpers for mem_access_unit.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  localparam logic [3:0] STRB_BYTE = 4'b0001;
  localparam logic [3:0] STRB_HALF = 4'b0011;
  localparam logic [3:0] STRB_WORD = 4'b1111;

  // A word access always starts at lane 0; sub-word accesses use the low address bits.
  function automatic logic [1:0] lane_of(input mem_size_t size, input logic [1:0] a);
    return (size == WORD) ? 2'b00 : a;
  endfunction

  function automatic logic misaligned(input mem_size_t size, input logic [1:0] a);
    return ((size == HALF) && a[0]) || ((size == WORD) && (a != 2'b00));
  endfunction

  function automatic logic [3:0] strobe_of(input mem_size_t size, input logic [1:0] lane);
    case (size)
      BYTE:    return STRB_BYTE << lane;
      HALF:    return STRB_HALF << lane;
      default: return STRB_WORD;
    endcase
  endfunction

  // Bytes pushed past lane 3 fall off the top of the word.
  function automatic logic [31:0] wdata_of(input mem_size_t size, input logic [1:0] lane,
                                           input logic [31:0] data);
    logic [31:0] value;
    case (size)
      BYTE:    value = {24'h0, data[7:0]};
      HALF:    value = {16'h0, data[15:0]};
      default: value = data;
    endcase
    return value << {lane, 3'b000};
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Combinational load aligner: shift bus_rdata down by the captured lane, truncate, extend.
module load_align
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        lane,
  input  mem_size_t         size,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] shifted;
  logic              sign_bit;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    shifted  = rdata >> {lane, 3'b000};
    sign_bit = 1'b0;
    data     = shifted;
    case (size)
      BYTE: begin
        sign_bit = ~is_unsigned & shifted[7];
        data     = {{(DATA_W-8){sign_bit}}, shifted[7:0]};
      end
      HALF: begin
        sign_bit = ~is_unsigned & shifted[15];
        data     = {{(DATA_W-16){sign_bit}}, shifted[15:0]};
      end
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access controller: single-outstanding req/gnt/rvalid transaction with stall.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ALUResult_m,
  input  logic [DATA_W-1:0] StoreData_m,
  input  logic              MemR_m,
  input  logic              MemW_m,
  input  mem_size_t         size_m,
  input  logic              unsigned_m,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [3:0]        bus_wstrb,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [DATA_W-1:0] load_data_m,
  output logic              stall_m,
  output logic              misalign_m
);

  mem_state_t        state;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wstrb_q;
  logic [1:0]        lane_q;
  mem_size_t         size_q;
  logic              unsigned_q;

  logic              access_req;
  logic              access_bad;
  logic              start;
  logic [1:0]        lane_in;
  logic [DATA_W-1:0] aligned_rdata;

  assign access_req = MemR_m | MemW_m;
  assign lane_in    = lane_of(size_m, ALUResult_m[1:0]);

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_q;
  assign access_bad = misaligned(size_m, ALUResult_m[1:0]);
  assign misalign_m = misalign_q;
`else
  assign access_bad = 1'b0;
  assign misalign_m = 1'b0;
`endif

  // Gated by reset so a held MemR/MemW cannot raise stall_m while the unit is held in reset.
  assign start = reset & access_req & ~access_bad;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      lane_q      <= 2'b00;
      size_q      <= BYTE;
      unsigned_q  <= 1'b0;
      load_data_m <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q <= (state == IDLE) && access_req && access_bad;
`endif
      // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
      case (state)
        IDLE: begin
          if (start) begin
            addr_q     <= {ALUResult_m[ADDR_W-1:2], 2'b00};
            we_q       <= MemW_m;
            wdata_q    <= wdata_of(size_m, lane_in, StoreData_m);
            wstrb_q    <= strobe_of(size_m, lane_in);
            lane_q     <= lane_in;
            size_q     <= size_m;
            unsigned_q <= unsigned_m;
            state      <= REQ;
          end
        end
        REQ: begin
          if (bus_gnt) state <= we_q ? DONE : RESP;
        end
        RESP: begin
          if (bus_rvalid) begin
            load_data_m <= aligned_rdata;
            state       <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  load_align #(.DATA_W(DATA_W)) u_load_align (
    .lane        (lane_q),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .rdata       (bus_rdata),
    .data        (aligned_rdata)
  );

  assign bus_req   = (state == REQ);
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_wstrb = wstrb_q;
  assign stall_m   = (state == REQ) || (state == RESP) || ((state == IDLE) && start);

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized and directed bench for mem_access_unit against a byte-level reference model.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ALUResult_m, StoreData_m;
  logic        MemR_m, MemW_m, unsigned_m;
  mem_size_t   size_m;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata, load_data_m;
  logic        stall_m, misalign_m;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] last_load = 32'h0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .reset(reset), .ALUResult_m(ALUResult_m), .StoreData_m(StoreData_m),
    .MemR_m(MemR_m), .MemW_m(MemW_m), .size_m(size_m), .unsigned_m(unsigned_m),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .load_data_m(load_data_m), .stall_m(stall_m), .misalign_m(misalign_m)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference model: byte lanes computed from the access size and address.
  function automatic int model_lane(mem_size_t s, logic [31:0] a);
    return (s == WORD) ? 0 : int'(a[1:0]);
  endfunction

  function automatic int model_nbytes(mem_size_t s);
    case (s)
      BYTE:    return 1;
      HALF:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [3:0] model_strb(mem_size_t s, logic [31:0] a);
    logic [3:0] r = 4'b0;
    int l = model_lane(s, a);
    int n = model_nbytes(s);
    for (int i = 0; i < 4; i++) if (i >= l && i < l + n) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] model_wdata(mem_size_t s, logic [31:0] a, logic [31:0] d);
    logic [31:0] r = 32'h0;
    int l = model_lane(s, a);
    int n = model_nbytes(s);
    for (int i = 0; i < 4; i++) if (i >= l && i < l + n) r[8*i +: 8] = d[8*(i-l) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(mem_size_t s, logic [31:0] a, logic uns, logic [31:0] rd);
    logic [31:0] v = 32'h0;
    int l = model_lane(s, a);
    int n = model_nbytes(s);
    for (int k = 0; k < n; k++) if (l + k < 4) v[8*k +: 8] = rd[8*(l+k) +: 8];
    if (!uns && n < 4 && v[8*n-1]) for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
    return v;
  endfunction

  // One complete transaction, checked cycle by cycle against the expected timeline.
  task automatic run_access(input logic wr, input logic rd_en, input logic [31:0] addr,
                            input logic [31:0] sdata, input mem_size_t size, input logic uns,
                            input int gd, input int rvd, input logic [31:0] rdata, input string tag);
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_strb;
    exp_addr  = {addr[31:2], 2'b00};
    exp_wdata = model_wdata(size, addr, sdata);
    exp_strb  = model_strb(size, addr);

    ALUResult_m = addr; StoreData_m = sdata; MemW_m = wr; MemR_m = rd_en;
    size_m = size; unsigned_m = uns; bus_gnt = 1'b0; bus_rvalid = 1'b0;
    #1;
    n_checks++; if (stall_m !== 1'b1) $display("FAIL %s idle_stall: got %0b want 1", tag, stall_m); else n_pass++;
    n_checks++; if (bus_req !== 1'b0) $display("FAIL %s idle_req: got %0b want 0", tag, bus_req); else n_pass++;
    @(negedge clk);

    for (int g = 0; g <= gd; g++) begin
      bus_gnt = (g == gd); bus_rvalid = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
      #1;
      n_checks++; if (bus_req !== 1'b1) $display("FAIL %s req_req[%0d]: got %0b want 1", tag, g, bus_req); else n_pass++;
      n_checks++; if (stall_m !== 1'b1) $display("FAIL %s req_stall[%0d]: got %0b want 1", tag, g, stall_m); else n_pass++;
      n_checks++; if (bus_addr !== exp_addr) $display("FAIL %s req_addr[%0d]: got %h want %h", tag, g, bus_addr, exp_addr); else n_pass++;
      n_checks++; if (bus_we !== wr) $display("FAIL %s req_we[%0d]: got %0b want %0b", tag, g, bus_we, wr); else n_pass++;
      n_checks++; if (bus_wstrb !== exp_strb) $display("FAIL %s req_strb[%0d]: got %b want %b", tag, g, bus_wstrb, exp_strb); else n_pass++;
      n_checks++; if (bus_wdata !== exp_wdata) $display("FAIL %s req_wdata[%0d]: got %h want %h", tag, g, bus_wdata, exp_wdata); else n_pass++;
      @(negedge clk);
    end
    bus_gnt = 1'b0;

    if (!wr) begin
      for (int r = 0; r <= rvd; r++) begin
        bus_rvalid = (r == rvd); bus_rdata = (r == rvd) ? rdata : $urandom;
        #1;
        n_checks++; if (bus_req !== 1'b0) $display("FAIL %s resp_req[%0d]: got %0b want 0", tag, r, bus_req); else n_pass++;
        n_checks++; if (stall_m !== 1'b1) $display("FAIL %s resp_stall[%0d]: got %0b want 1", tag, r, stall_m); else n_pass++;
        @(negedge clk);
      end
      last_load = model_load(size, addr, uns, rdata);
    end

    // DONE cycle: pipeline advances; a stray rvalid here must be ignored.
    MemR_m = 1'b0; MemW_m = 1'b0; bus_rvalid = 1'b1; bus_rdata = $urandom;
    #1;
    n_checks++; if (stall_m !== 1'b0) $display("FAIL %s done_stall: got %0b want 0", tag, stall_m); else n_pass++;
    n_checks++; if (bus_req !== 1'b0) $display("FAIL %s done_req: got %0b want 0", tag, bus_req); else n_pass++;
    n_checks++; if (load_data_m !== last_load) $display("FAIL %s done_load: got %h want %h", tag, load_data_m, last_load); else n_pass++;
    n_checks++; if (misalign_m !== 1'b0) $display("FAIL %s done_misalign: got %0b want 0", tag, misalign_m); else n_pass++;
    @(negedge clk);
    bus_rvalid = 1'b0;
    #1;
    n_checks++; if (load_data_m !== last_load) $display("FAIL %s idle_hold_load: got %h want %h", tag, load_data_m, last_load); else n_pass++;
    n_checks++; if (bus_req !== 1'b0 || stall_m !== 1'b0) $display("FAIL %s no_reissue: got req=%0b stall=%0b want 0/0", tag, bus_req, stall_m); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; ALUResult_m = 32'h0; StoreData_m = 32'h0; MemR_m = 1'b1; MemW_m = 1'b0;
    size_m = WORD; unsigned_m = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (bus_req !== 1'b0) $display("FAIL reset_req: got %0b want 0", bus_req); else n_pass++;
    n_checks++; if (bus_we !== 1'b0) $display("FAIL reset_we: got %0b want 0", bus_we); else n_pass++;
    n_checks++; if (bus_addr !== 32'h0) $display("FAIL reset_addr: got %h want 0", bus_addr); else n_pass++;
    n_checks++; if (bus_wdata !== 32'h0) $display("FAIL reset_wdata: got %h want 0", bus_wdata); else n_pass++;
    n_checks++; if (bus_wstrb !== 4'h0) $display("FAIL reset_wstrb: got %h want 0", bus_wstrb); else n_pass++;
    n_checks++; if (load_data_m !== 32'h0) $display("FAIL reset_load: got %h want 0", load_data_m); else n_pass++;
    n_checks++; if (stall_m !== 1'b0) $display("FAIL reset_stall: got %0b want 0", stall_m); else n_pass++;
    n_checks++; if (misalign_m !== 1'b0) $display("FAIL reset_misalign: got %0b want 0", misalign_m); else n_pass++;
    MemR_m = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_store_word();
    run_access(1'b1, 1'b0, 32'h100, 32'hDEADBEEF, WORD, 1'b0, 0, 0, 32'h0, "store_word");
    n_checks++; if (bus_wdata !== 32'hDEADBEEF || bus_wstrb !== 4'hF || bus_addr !== 32'h100)
      $display("FAIL store_word_bus: got %h/%h/%h want DEADBEEF/f/00000100", bus_wdata, bus_wstrb, bus_addr);
    else n_pass++;
  endtask

  task automatic test_load_byte_signed();
    run_access(1'b0, 1'b1, 32'h203, $urandom, BYTE, 1'b0, 0, 0, 32'h80FF_0000, "load_byte_s");
    n_checks++; if (load_data_m !== 32'hFFFFFF80) $display("FAIL load_byte_s_value: got %h want ffffff80", load_data_m); else n_pass++;
    n_checks++; if (bus_addr !== 32'h200) $display("FAIL load_byte_s_addr: got %h want 00000200", bus_addr); else n_pass++;
  endtask

  task automatic test_load_half_delayed();
    run_access(1'b0, 1'b1, 32'h302, $urandom, HALF, 1'b1, 3, 2, 32'hBEEF_1234, "load_half_u");
    n_checks++; if (load_data_m !== 32'h0000BEEF) $display("FAIL load_half_u_value: got %h want 0000beef", load_data_m); else n_pass++;
  endtask

  task automatic test_store_byte();
    run_access(1'b1, 1'b0, 32'h11, 32'h000000AB, BYTE, 1'b0, 1, 0, 32'h0, "store_byte");
    n_checks++; if (bus_wstrb !== 4'b0010 || bus_wdata[15:8] !== 8'hAB)
      $display("FAIL store_byte_lane: got strb=%b byte=%h want 0010/ab", bus_wstrb, bus_wdata[15:8]);
    else n_pass++;
  endtask

  task automatic test_store_wins();
    run_access(1'b1, 1'b1, 32'h44, 32'h1234_5678, HALF, 1'b0, 0, 0, 32'h0, "store_wins");
  endtask

  task automatic test_misalign_word();
`ifdef MEM_MISALIGN_TRAP_EN
    int seen_req = 0;
    ALUResult_m = 32'h6; MemR_m = 1'b1; MemW_m = 1'b0; size_m = WORD; unsigned_m = 1'b0;
    #1;
    n_checks++; if (stall_m !== 1'b0) $display("FAIL trap_stall: got %0b want 0", stall_m); else n_pass++;
    @(negedge clk);
    MemR_m = 1'b0;
    #1;
    if (bus_req) seen_req++;
    n_checks++; if (misalign_m !== 1'b1) $display("FAIL trap_pulse: got %0b want 1", misalign_m); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      if (bus_req) seen_req++;
      n_checks++; if (misalign_m !== 1'b0) $display("FAIL trap_pulse_end[%0d]: got %0b want 0", i, misalign_m); else n_pass++;
    end
    n_checks++; if (seen_req != 0) $display("FAIL trap_no_req: got %0d req cycles want 0", seen_req); else n_pass++;
    @(negedge clk);
`else
    run_access(1'b0, 1'b1, 32'h6, $urandom, WORD, 1'b0, 0, 1, 32'hCAFE_F00D, "misalign_word");
    n_checks++; if (bus_addr !== 32'h4) $display("FAIL misalign_word_addr: got %h want 00000004", bus_addr); else n_pass++;
    n_checks++; if (load_data_m !== 32'hCAFEF00D) $display("FAIL misalign_word_value: got %h want cafef00d", load_data_m); else n_pass++;
`endif
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      logic        wr;
      mem_size_t   sz;
      logic [31:0] addr;
      wr   = 1'($urandom_range(0, 1));
      sz   = mem_size_t'($urandom_range(0, 2));
      addr = $urandom;
`ifdef MEM_MISALIGN_TRAP_EN
      if (sz == WORD) addr[1:0] = 2'b00;
      if (sz == HALF) addr[0] = 1'b0;
`endif
      run_access(wr, ~wr | 1'($urandom_range(0, 1)), addr, $urandom, sz, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom, $sformatf("rand%0d", t));
    end
  endtask

  task automatic test_reset_mid();
    ALUResult_m = 32'h40; MemR_m = 1'b1; MemW_m = 1'b0; size_m = WORD; unsigned_m = 1'b0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_checks++; if (bus_req !== 1'b0) $display("FAIL reset_in_req: got %0b want 0", bus_req); else n_pass++;
    MemR_m = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    MemR_m = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    #1;
    n_checks++; if (stall_m !== 1'b1) $display("FAIL resp_before_reset: got %0b want 1", stall_m); else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++; if (bus_req !== 1'b0 || stall_m !== 1'b0)
      $display("FAIL reset_in_resp: got req=%0b stall=%0b want 0/0", bus_req, stall_m);
    else n_pass++;
    MemR_m = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678;
    repeat (2) @(negedge clk);
    bus_rvalid = 1'b0;
    #1;
    n_checks++; if (load_data_m !== 32'h0) $display("FAIL abandoned_resp: got %h want 0", load_data_m); else n_pass++;
    n_checks++; if (bus_req !== 1'b0 || stall_m !== 1'b0)
      $display("FAIL after_reset_idle: got req=%0b stall=%0b want 0/0", bus_req, stall_m);
    else n_pass++;
    last_load = 32'h0;
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_byte_signed();
    test_load_half_delayed();
    test_store_byte();
    test_store_wins();
    test_misalign_word();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
